// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings and FSM state type for the ALU execute stage
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SR   = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SR);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - combinational add/sub, compare and bitwise ops; shift ops yield zero here
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            sel,
    output logic [XLEN-1:0] y
);

    logic [XLEN:0] diff;
    logic          lt_signed;
    logic          lt_unsigned;

    always_comb begin
        // One extended subtract serves sub and both compares; its carry-out is the unsigned borrow.
        diff        = {1'b0, a} - {1'b0, b};
        lt_unsigned = diff[XLEN];
        lt_signed   = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

        y = '0;
        case (op)
            OP_ADD:  y = sel ? diff[XLEN-1:0] : (a + b);
            OP_SLT:  y = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with handshakes, iterative shifter and zero flag
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            sel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                right_q, right_d;
    logic                arith_q, arith_d;
    logic                zero_q, zero_d;

    logic [XLEN-1:0]     comb_y;
    logic [XLEN-1:0]     acc_step;
    logic [SHAMT_W-1:0]  shamt;
    logic                accept;

    alu_comb_core #(.XLEN(XLEN)) u_comb_core (
        .a   (a),
        .b   (b),
        .op  (op),
        .sel (sel),
        .y   (comb_y)
    );

    always_comb begin
        shamt  = b[SHAMT_W-1:0];
        accept = in_valid && (state_q == IDLE);

        if (right_q) begin
            acc_step = {arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]};
        end else begin
            acc_step = {acc_q[XLEN-2:0], 1'b0};
        end

        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        right_d  = right_q;
        arith_d  = arith_q;
        result_d = result_q;
        zero_d   = zero_q;

        // Flush wins over everything, including a same-cycle handshake and a final shift step.
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_shift_op(op) && (shamt != '0)) begin
                            acc_d   = a;
                            cnt_d   = shamt;
                            right_d = (op == OP_SR);
                            arith_d = (op == OP_SR) && sel;
                            state_d = SHIFT;
                        end else begin
                            result_d = is_shift_op(op) ? a : comb_y;
                            zero_d   = (result_d == '0);
                            state_d  = DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_d = acc_step;
                        zero_d   = (acc_step == '0);
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            right_q  <= 1'b0;
            arith_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            right_q  <= right_d;
            arith_q  <= arith_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit with a behavioural reference model
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sel;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .sel       (sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] o, input logic s);
        int unsigned sh;
        logic signed [31:0] sx;
        sh = y % 32;
        sx = x;
        case (o)
            3'd0:    return s ? (x - y) : (x + y);
            3'd1:    return x << sh;
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return s ? 32'(sx >>> sh) : (x >> sh);
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [2:0] top, input logic tsel, input logic [31:0] exp_res);
        int lat;
        int exp_lat;
        logic busy_ok;
        exp_lat = ((top == 3'd1 || top == 3'd5) && (tb_ % 32) != 0) ? int'(tb_ % 32) + 1 : 1;
        @(negedge clk);
        a = ta; b = tb_; op = top; sel = tsel; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom); sel = 1'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " in_ready_busy"}, 32'(busy_ok), 32'd1);
        check({tag, " result"}, result, exp_res);
        check({tag, " zero"}, 32'(zero), 32'(exp_res == 32'd0));
        @(posedge clk);
        #1;
        check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic never_valid;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic        rsel;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; sel = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", 32'd5, 32'd7, 3'd0, 1'b0, 32'd12);
        run_op("sub_eq", 32'h1234, 32'h1234, 3'd0, 1'b1, 32'd0);
        run_op("sub_neg", 32'd0, 32'd1, 3'd0, 1'b1, 32'hFFFF_FFFF);
        run_op("sra4", 32'h8000_0000, 32'd4, 3'd5, 1'b1, 32'hF800_0000);
        run_op("srl4", 32'h8000_0000, 32'd4, 3'd5, 1'b0, 32'h0800_0000);
        run_op("sll31", 32'd1, 32'h3F, 3'd1, 1'b0, 32'h8000_0000);
        run_op("sll_shamt0", 32'hDEAD_BEEF, 32'h20, 3'd1, 1'b0, 32'hDEAD_BEEF);
        run_op("slt_neg", 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 32'd1);
        run_op("sltu_big", 32'hFFFF_FFFF, 32'd1, 3'd3, 1'b1, 32'd0);
        run_op("slt_eq", 32'h55AA, 32'h55AA, 3'd2, 1'b1, 32'd0);
        run_op("sltu_eq", 32'h55AA, 32'h55AA, 3'd3, 1'b0, 32'd0);

        // Stall in DONE with a competing request on the input side.
        @(negedge clk);
        a = 32'd3; b = 32'd4; op = 3'd0; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 32'd100; b = 32'd1; op = 3'd6; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall result", result, 32'd7);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall release in_ready", 32'(in_ready), 32'd1);
        check("stall release result", result, 32'd7);

        // Flush on the second shift edge of a shamt=10 shift.
        @(negedge clk);
        a = 32'd1; b = 32'd10; op = 3'd1; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush result kept", result, 32'd7);
        @(negedge clk);
        flush = 1'b0;
        never_valid = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) never_valid = 1'b0;
        end
        check("flush no out_valid", 32'(never_valid), 32'd1);

        // Handshake coinciding with flush is dropped.
        @(negedge clk);
        a = 32'd1; b = 32'd1; op = 3'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_hs in_ready", 32'(in_ready), 32'd1);
        check("flush_hs out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check("flush_hs dropped", 32'(out_valid), 32'd0);
        check("flush_hs result kept", result, 32'd7);

        // Reset in the middle of a shift.
        @(negedge clk);
        a = 32'h8000_0000; b = 32'd20; op = 3'd5; sel = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst result", result, 32'd0);
        check("midrst zero", 32'(zero), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            rb   = (i % 4 == 0) ? ra : $urandom;
            rop  = 3'($urandom);
            rsel = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rop, rsel, ref_alu(ra, rb, rop, rsel));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit `op` / 1-bit `sel` pair produced by the ALU control decoder and the two operands, and returns a registered result.
- Single-cycle for arithmetic, logic and compare ops; iterative one-bit-per-cycle for shifts.
- valid/ready handshake on both sides so the core can stall it.
- Also produces the `zero` flag used for branch resolution.

Parameters:
- XLEN, 32, operand/result width
- SHAMT_W, $clog2(XLEN), shift-amount width taken from operand b

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  unit can accept (high only in IDLE)
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2 or immediate)
- op  input  3  operation, funct3 encoding
- sel  input  1  variant select: sub for op 000, arithmetic shift for op 101
- flush  input  1  abort current operation
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  registered, result==0

Behaviour:
- Single clock `clk`; reset synchronous, active-low on `rst_n`.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, shift counter=0.
- Op decode:
  - 000: a+b (sel=0) or a-b (sel=1)
  - 001: SLL
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL (sel=0) or SRA (sel=1)
  - 110: OR
  - 111: AND
- sel is ignored for all ops except 000 and 101. Compares always use an internal subtract/compare regardless of sel.
- Shift amount = b[SHAMT_W-1:0]; upper bits of b ignored. Add/sub wrap modulo 2^XLEN; no overflow flag.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Handshake (in_valid & in_ready) with a non-shift op, or a shift with shamt==0: result and zero load at that edge, go to DONE.
  - Handshake with a shift and shamt!=0: latch acc=a, cnt=shamt, direction/arith flag; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge: acc shifted by 1 (left; logical right; arithmetic right replicating acc[XLEN-1]) and cnt decrements.
  - When cnt==1 at the edge: result=shifted acc, zero updated, go to DONE.
- DONE:
  - out_valid=1, in_ready=0; result and zero held stable.
  - out_valid & out_ready: go to IDLE next edge. No back-to-back acceptance in the same cycle.
- Latency, counted from the handshake edge to out_valid high:
  - 1 cycle for non-shift ops and shamt==0.
  - shamt+1 cycles for shifts; maximum XLEN cycles at shamt=XLEN-1.
- Inputs a/b/op/sel are sampled only on the handshake edge. Changes at any other time are ignored.
- flush (priority below rst_n, above everything else):
  - Next state IDLE; out_valid=0.
  - result/zero retain their last value.
  - A handshake in the same cycle as flush is dropped.
- rst_n low in any state, including mid-shift, returns all outputs to their reset values at that edge.
- in_valid while in SHIFT/DONE is not accepted; the producer must hold it.

Decomposition:
- Shared package alu_pkg holds:
  - op localparams: OP_ADD=000, OP_SLL=001, OP_SLT=010, OP_SLTU=011, OP_XOR=100, OP_SR=101, OP_OR=110, OP_AND=111
  - FSM state encoding: IDLE, SHIFT, DONE
- The ALU control decoder imports the same op constants.
- One sub-module: alu_comb_core. It is purely combinational, computes every non-shift op from (a, b, op, sel), and is instantiated once. The shift datapath and FSM stay in alu_exec_unit.

Test Plan:
- Add: a=5, b=7, op=000, sel=0, out_ready=1 -> out_valid high 1 cycle after handshake, result=12, zero=0, in_ready back to 1 the following cycle.
- Branch subtract: a=b=0x00001234, op=000, sel=1 -> result=0, zero=1. Then a=0, b=1, sel=1 -> result=0xFFFFFFFF, zero=0.
- SRA vs SRL: a=0x80000000, b=4, op=101, sel=1 -> result=0xF8000000 with out_valid 5 cycles after handshake and in_ready low throughout. Same with sel=0 -> 0x08000000. b=0x0000003F with SLL of a=1 -> 0x80000000 after 32 cycles.
- Shift masking and shamt zero: b=0x00000020 (shamt=0), op=001, a=0xDEADBEEF -> result=0xDEADBEEF, latency 1.
- Compares: a=0xFFFFFFFF, b=1 -> SLT result=1, SLTU result=0. a=b -> both 0, zero=1.
- Stall/abort/reset:
  - out_ready held low 3 cycles in DONE -> result/out_valid stable, no new input accepted.
  - flush asserted 2 cycles into a shamt=10 shift -> IDLE next cycle, out_valid never rises, in_ready=1.
  - rst_n low mid-shift -> result=0, zero=0, out_valid=0 at that edge.
